// File: rtl/sd_resp_pkg.sv
// Shared types and constants for the sector-buffer target (sd_sector_responder).
package sd_resp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK_SETUP,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR,
    S_WR_WAIT,
    S_WR_CAP,
    S_DONE
  } state_e;

  localparam int unsigned SECTOR_BYTES  = 512;
  localparam int unsigned IDX_W         = 9;
  localparam int unsigned ACK_SETUP_CYC = 2;
  localparam logic [7:0]  OOB_FILL      = 8'hFF;

endpackage

// File: rtl/sd_sector_responder.sv
// Target side of the sd_* sector-buffer handshake, serving 512-byte sectors
// from a local single-port byte RAM (mem_q valid one clock after mem_rd).
module sd_sector_responder
  import sd_resp_pkg::*;
#(
  parameter int unsigned LBA_W   = 6,
  parameter int unsigned DIN_LAT = 1,
  parameter int unsigned GAP     = 2
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [31:0]        sd_lba,
  input  logic               sd_rd,
  input  logic               sd_wr,
  output logic               sd_ack,
  output logic [8:0]         sd_buff_addr,
  output logic [7:0]         sd_buff_dout,
  output logic               sd_buff_wr,
  input  logic [7:0]         sd_buff_din,
  output logic [LBA_W+8:0]   mem_addr,
  output logic               mem_rd,
  input  logic [7:0]         mem_q,
  output logic               mem_wr,
  output logic [7:0]         mem_d,
  output logic               busy,
  output logic               range_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(ACK_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((DIN_LAT > 1) ? DIN_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(SECTOR_BYTES - 1);

  state_e             state_q, state_d;
  logic [LBA_W-1:0]   lba_q, lba_d;
  logic               wr_dir_q, wr_dir_d;
  logic               oob_q, oob_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_nx;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic [8:0]         buff_addr_q, buff_addr_d;
  logic [7:0]         buff_dout_q, buff_dout_d;
  logic               buff_wr_q, buff_wr_d;
  logic [LBA_W+8:0]   mem_addr_q, mem_addr_d;
  logic               mem_rd_q, mem_rd_d;
  logic               mem_wr_q, mem_wr_d;
  logic [7:0]         mem_d_q, mem_d_d;
  logic               busy_q, busy_d;
  logic               range_err_q, range_err_d;
  logic               req_oob;

  assign idx_nx  = idx_q + 9'd1;
  assign req_oob = |sd_lba[31:LBA_W];

  // Registered outputs are loaded on the transition that enters the state in
  // which they must be valid, so RAM and initiator see them for a full clock.
  always_comb begin
    state_d     = state_q;
    lba_d       = lba_q;
    wr_dir_d    = wr_dir_q;
    oob_d       = oob_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    ack_d       = ack_q;
    buff_addr_d = buff_addr_q;
    buff_dout_d = buff_dout_q;
    buff_wr_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_d_d     = mem_d_q;
    range_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sd_rd || sd_wr) begin
          state_d     = S_ACK_SETUP;
          lba_d       = sd_lba[LBA_W-1:0];
          wr_dir_d    = ~sd_rd;
          oob_d       = req_oob;
          idx_d       = '0;
          cnt_d       = '0;
          range_err_d = req_oob;
        end
      end
      S_ACK_SETUP: begin
        ack_d = 1'b1;
        if (cnt_q == SETUP_LAST) begin
          cnt_d = '0;
          if (wr_dir_q) begin
            state_d     = S_WR_ADDR;
            buff_addr_d = idx_q;
          end else begin
            state_d    = S_RD_ADDR;
            mem_addr_d = {lba_q, idx_q};
            mem_rd_d   = ~oob_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RD_ADDR: state_d = S_RD_DATA;
      S_RD_DATA: begin
        buff_addr_d = idx_q;
        buff_dout_d = oob_q ? OOB_FILL : mem_q;
        buff_wr_d   = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          state_d    = S_RD_ADDR;
          idx_d      = idx_nx;
          mem_addr_d = {lba_q, idx_nx};
          mem_rd_d   = ~oob_q;
        end
      end
      S_WR_ADDR: begin
        cnt_d   = '0;
        state_d = (DIN_LAT > 1) ? S_WR_WAIT : S_WR_CAP;
      end
      S_WR_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = S_WR_CAP;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      S_WR_CAP: begin
        mem_d_d    = sd_buff_din;
        mem_addr_d = {lba_q, idx_q};
        mem_wr_d   = ~oob_q;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          state_d     = S_WR_ADDR;
          idx_d       = idx_nx;
          buff_addr_d = idx_nx;
        end
      end
      S_DONE: begin
        ack_d = 1'b0;
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      lba_q       <= '0;
      wr_dir_q    <= 1'b0;
      oob_q       <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      buff_addr_q <= '0;
      buff_dout_q <= '0;
      buff_wr_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_d_q     <= '0;
      busy_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lba_q       <= lba_d;
      wr_dir_q    <= wr_dir_d;
      oob_q       <= oob_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      buff_addr_q <= buff_addr_d;
      buff_dout_q <= buff_dout_d;
      buff_wr_q   <= buff_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_d_q     <= mem_d_d;
      busy_q      <= busy_d;
      range_err_q <= range_err_d;
    end
  end

  assign sd_ack       = ack_q;
  assign sd_buff_addr = buff_addr_q;
  assign sd_buff_dout = buff_dout_q;
  assign sd_buff_wr   = buff_wr_q;
  assign mem_addr     = mem_addr_q;
  assign mem_rd       = mem_rd_q;
  assign mem_wr       = mem_wr_q;
  assign mem_d        = mem_d_q;
  assign busy         = busy_q;
  assign range_err    = range_err_q;

endmodule

// File: tb/tb_sd_sector_responder.sv
// Directed bench for sd_sector_responder: byte RAM model, 2-clock initiator
// buffer model and a negedge monitor feeding immediate-assertion checks.
module tb_sd_sector_responder;

  localparam int unsigned LBA_W   = 6;
  localparam int unsigned DIN_LAT = 2;
  localparam int unsigned GAP     = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [31:0]       sd_lba;
  logic              sd_rd, sd_wr;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din;
  logic [LBA_W+8:0]  mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_q;
  logic              mem_wr;
  logic [7:0]        mem_d;
  logic              busy;
  logic              range_err;

  sd_sector_responder #(.LBA_W(LBA_W), .DIN_LAT(DIN_LAT), .GAP(GAP)) dut (
    .clk_sys(clk), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_q(mem_q), .mem_wr(mem_wr), .mem_d(mem_d),
    .busy(busy), .range_err(range_err)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram    [0:32767];
  logic [7:0]  shadow [0:32767];
  logic        do_preload;
  logic [7:0]  key;
  logic [7:0]  p1, p2;
  logic [31:0] cur_lba;
  logic        cur_oob;
  logic        gap_arm;

  function automatic logic [7:0] pat(input int a);
    logic [14:0] v;
    v = 15'(a);
    return v[7:0] ^ 8'h5A ^ {2'b00, v[14:9]} ^ 8'h05;
  endfunction

  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < 32768; i++) ram[i] <= pat(i);
    end else begin
      if (mem_wr) ram[mem_addr] <= mem_d;
      if (mem_rd) mem_q <= ram[mem_addr];
    end
  end

  always @(posedge clk) begin
    p1 <= key ^ sd_buff_addr[7:0];
    p2 <= p1;
  end
  assign sd_buff_din = p2;

  function automatic logic [7:0] exp_byte(input int a);
    return cur_oob ? 8'hFF : shadow[int'(cur_lba[5:0]) * 512 + a];
  endfunction

  int bwr_cnt = 0, mwr_cnt = 0, mrd_cnt = 0, rerr_cnt = 0, rd_bad = 0, both_bad = 0;
  int ack_rises = 0, ack_run = 0, last_ack_len = 0, since_fall = 0;
  int busy_rise_gap = 0, min_gap = 1000000, next_addr = 0;
  logic ack_prev = 1'b0, busy_prev = 1'b0;

  always @(negedge clk) begin
    if (sd_buff_wr) begin
      bwr_cnt++;
      if (!sd_ack || sd_buff_addr != 9'(next_addr) || sd_buff_dout !== exp_byte(next_addr)) rd_bad++;
      next_addr++;
    end
    if (!sd_ack) next_addr = 0;
    if (mem_rd) mrd_cnt++;
    if (mem_wr) mwr_cnt++;
    if (mem_rd && mem_wr) both_bad++;
    if (range_err) rerr_cnt++;
    if (sd_ack) ack_run++;
    if (ack_prev && !sd_ack) begin
      last_ack_len = ack_run;
      ack_run = 0;
      since_fall = 0;
    end else begin
      since_fall++;
    end
    if (sd_ack && !ack_prev) begin
      ack_rises++;
      if (gap_arm && since_fall < min_gap) min_gap = since_fall;
    end
    if (!gap_arm) min_gap = 1000000;
    if (busy && !busy_prev) busy_rise_gap = since_fall;
    ack_prev = sd_ack;
    busy_prev = busy;
  end

  int n_checks = 0, n_fail = 0;
  int s_bwr, s_mwr, s_mrd, s_rerr, s_bad, s_rises;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_bwr = bwr_cnt; s_mwr = mwr_cnt; s_mrd = mrd_cnt;
    s_rerr = rerr_cnt; s_bad = rd_bad; s_rises = ack_rises;
  endtask

  task automatic wait_ack(input logic val, input string tag);
    int n = 0;
    while (sd_ack !== val && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, sd_ack, val);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_after_done", busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_xfer(input logic rd, input logic wr, input logic [31:0] lba);
    cur_lba = lba;
    cur_oob = |lba[31:LBA_W];
    sd_lba = lba; sd_rd = rd; sd_wr = wr;
    wait_ack(1'b1, "ack_rise");
    @(negedge clk);
    sd_rd = 1'b0; sd_wr = 1'b0;
    wait_ack(1'b0, "ack_fall");
    wait_idle();
  endtask

  function automatic int sector_diff(input int s, input logic [7:0] k, input int upto);
    int bad = 0;
    for (int i = 0; i < 512; i++) begin
      if (i < upto) begin
        if (ram[s*512+i] !== (k ^ 8'(i))) bad++;
      end else if (ram[s*512+i] !== shadow[s*512+i]) bad++;
    end
    return bad;
  endfunction

  initial begin
    reset_n = 1'b0; do_preload = 1'b1; key = 8'h00; gap_arm = 1'b0;
    sd_lba = '0; sd_rd = 1'b0; sd_wr = 1'b0; cur_lba = '0; cur_oob = 1'b0;
    for (int i = 0; i < 32768; i++) shadow[i] = pat(i);
    repeat (3) @(negedge clk);
    do_preload = 1'b0;
    check("rst_ack", sd_ack, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_buff_wr", sd_buff_wr, 1'b0);
    check("rst_mem_strobes", {mem_rd, mem_wr, range_err}, 3'b000);
    check("rst_addrs", {sd_buff_addr, mem_addr}, '0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read of in-range sector 5
    snap();
    do_xfer(1'b1, 1'b0, 32'd5);
    check("rd5_strobes", bwr_cnt - s_bwr, 512);
    check("rd5_data_bad", rd_bad - s_bad, 0);
    check("rd5_ack_len", last_ack_len, 2 + 1024);
    check("rd5_mem_rd", mrd_cnt - s_mrd, 512);
    check("rd5_range_err", rerr_cnt - s_rerr, 0);

    // Write sector 63 through the 2-clock initiator buffer
    key = 8'hC3;
    snap();
    do_xfer(1'b0, 1'b1, 32'd63);
    check("wr63_mem_wr", mwr_cnt - s_mwr, 512);
    check("wr63_buff_wr", bwr_cnt - s_bwr, 0);
    check("wr63_mem_rd", mrd_cnt - s_mrd, 0);
    check("wr63_ram_bad", sector_diff(63, 8'hC3, 512), 0);
    for (int i = 0; i < 512; i++) shadow[63*512+i] = 8'hC3 ^ 8'(i);

    // Out-of-range read and write
    snap();
    do_xfer(1'b1, 1'b0, 32'd64);
    check("oobrd_range_err", rerr_cnt - s_rerr, 1);
    check("oobrd_strobes", bwr_cnt - s_bwr, 512);
    check("oobrd_fill_bad", rd_bad - s_bad, 0);
    check("oobrd_mem_rd", mrd_cnt - s_mrd, 0);
    snap();
    do_xfer(1'b0, 1'b1, 32'd64);
    check("oobwr_range_err", rerr_cnt - s_rerr, 1);
    check("oobwr_mem_wr", mwr_cnt - s_mwr, 0);
    check("oobwr_sector0_bad", sector_diff(0, 8'h00, 0), 0);

    // Simultaneous rd+wr: read wins, held write runs after DONE
    key = 8'h11;
    snap();
    cur_lba = 32'd7; cur_oob = 1'b0;
    sd_lba = 32'd7; sd_rd = 1'b1; sd_wr = 1'b1;
    wait_ack(1'b1, "sim_ack_rise");
    @(negedge clk);
    sd_rd = 1'b0;
    wait_ack(1'b0, "sim_ack_fall");
    check("sim_rd_strobes", bwr_cnt - s_bwr, 512);
    check("sim_rd_data_bad", rd_bad - s_bad, 0);
    check("sim_rd_no_mem_wr", mwr_cnt - s_mwr, 0);
    snap();
    wait_ack(1'b1, "sim_wr_ack_rise");
    @(negedge clk);
    sd_wr = 1'b0;
    wait_ack(1'b0, "sim_wr_ack_fall");
    wait_idle();
    check("sim_wr_start_gap", busy_rise_gap, GAP + 1);
    check("sim_wr_mem_wr", mwr_cnt - s_mwr, 512);
    check("sim_wr_buff_wr", bwr_cnt - s_bwr, 0);
    check("sim_wr_ram_bad", sector_diff(7, 8'h11, 512), 0);
    for (int i = 0; i < 512; i++) shadow[7*512+i] = 8'h11 ^ 8'(i);

    // Back-to-back chain, re-requesting as soon as ack falls
    gap_arm = 1'b1;
    snap();
    for (int s = 0; s < 64; s++) begin
      cur_lba = 32'(s); cur_oob = 1'b0;
      sd_lba = 32'(s); sd_rd = 1'b1;
      wait_ack(1'b1, "chain_ack_rise");
      @(negedge clk);
      sd_rd = 1'b0;
      wait_ack(1'b0, "chain_ack_fall");
    end
    wait_idle();
    check("chain_acks", ack_rises - s_rises, 64);
    check("chain_bytes", bwr_cnt - s_bwr, 32768);
    check("chain_data_bad", rd_bad - s_bad, 0);
    check("chain_min_gap_ok", 32'(min_gap >= int'(GAP + 1)), 1);
    gap_arm = 1'b0;

    // Reset during byte 200 of a write to sector 10
    key = 8'h3C;
    cur_lba = 32'd10; cur_oob = 1'b0;
    sd_lba = 32'd10; sd_wr = 1'b1;
    wait_ack(1'b1, "rstwr_ack_rise");
    @(negedge clk);
    sd_wr = 1'b0;
    begin
      int n = 0;
      while (sd_buff_addr !== 9'd200 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("rstwr_reach_200", sd_buff_addr, 9'd200);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rstwr_ack", sd_ack, 1'b0);
    check("rstwr_mem_wr", mem_wr, 1'b0);
    check("rstwr_busy", busy, 1'b0);
    check("rstwr_buff_wr", sd_buff_wr, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rstwr_ram_bad", sector_diff(10, 8'h3C, 200), 0);
    for (int i = 0; i < 200; i++) shadow[10*512+i] = 8'h3C ^ 8'(i);

    snap();
    do_xfer(1'b1, 1'b0, 32'd10);
    check("postrst_strobes", bwr_cnt - s_bwr, 512);
    check("postrst_data_bad", rd_bad - s_bad, 0);
    check("postrst_ack_len", last_ack_len, 2 + 1024);
    check("never_rd_and_wr", both_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
